// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use bubble insertion, downstream stall and branch flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_pipeline_register #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [5:0]               id_function_code,
  input  logic [1:0]               id_alu_operation,
  input  logic [DATA_WIDTH-1:0]    id_read_data_1,
  input  logic [DATA_WIDTH-1:0]    id_read_data_2,
  input  logic [DATA_WIDTH-1:0]    id_immediate,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic [4:0]               id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic                     id_alu_src,
  input  logic                     id_reg_dst,
  input  logic                     ex_ready,
  output logic                     ex_valid,
  output logic [5:0]               ex_function_code,
  output logic [1:0]               ex_alu_operation,
  output logic [DATA_WIDTH-1:0]    ex_read_data_1,
  output logic [DATA_WIDTH-1:0]    ex_read_data_2,
  output logic [DATA_WIDTH-1:0]    ex_immediate,
  output logic [4:0]               ex_rs,
  output logic [4:0]               ex_rt,
  output logic [4:0]               ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic                     ex_alu_src,
  output logic                     ex_reg_dst,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [COUNTER_WIDTH-1:0] bubble_count,
`endif
  output logic [4:0]               ex_write_register
);

  logic advance;
  logic load_use;

  assign advance  = ex_ready | ~ex_valid;
  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign id_ready = reset_n & (flush | (advance & ~load_use));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_valid          <= 1'b0;
      ex_function_code  <= '0;
      ex_alu_operation  <= '0;
      ex_read_data_1    <= '0;
      ex_read_data_2    <= '0;
      ex_immediate      <= '0;
      ex_rs             <= '0;
      ex_rt             <= '0;
      ex_rd             <= '0;
      ex_reg_write      <= 1'b0;
      ex_mem_read       <= 1'b0;
      ex_mem_write      <= 1'b0;
      ex_mem_to_reg     <= 1'b0;
      ex_alu_src        <= 1'b0;
      ex_reg_dst        <= 1'b0;
      ex_write_register <= '0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
    end else if (advance) begin
      if (id_valid && !load_use) begin
        ex_valid          <= 1'b1;
        ex_function_code  <= id_function_code;
        ex_alu_operation  <= id_alu_operation;
        ex_read_data_1    <= id_read_data_1;
        ex_read_data_2    <= id_read_data_2;
        ex_immediate      <= id_immediate;
        ex_rs             <= id_rs;
        ex_rt             <= id_rt;
        ex_rd             <= id_rd;
        ex_reg_write      <= id_reg_write;
        ex_mem_read       <= id_mem_read;
        ex_mem_write      <= id_mem_write;
        ex_mem_to_reg     <= id_mem_to_reg;
        ex_alu_src        <= id_alu_src;
        ex_reg_dst        <= id_reg_dst;
        ex_write_register <= id_reg_dst ? id_rd : id_rt;
      end else begin
        // Bubble: payload is left as-is, only state-changing controls are killed.
        ex_valid      <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
      end
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bubble_count <= '0;
    end else if (advance && load_use && !flush && (bubble_count != '1)) begin
      bubble_count <= bubble_count + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`else
  if (COUNTER_WIDTH == 0) begin : g_no_bubble_counter
  end
`endif

endmodule
